// File: rtl/sat_arbiter_pkg.sv
// Shared types and helpers for the saturating arbiter: FSM state encoding,
// output width derivation and the grant index width helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package sat_arbiter_pkg;

  // FSM state encoding; the values are visible to host-side debug tools.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

  // Grant index width; a single requester still needs one bit.
  function automatic int idx_width(input int nreq);
    return (nreq < 2) ? 1 : clog2(nreq);
  endfunction

  // Result width after removing LTRUNC MSBs.
  function automatic int out_len(input int in_len, input int ltrunc);
    return in_len - ltrunc;
  endfunction

endpackage

// File: rtl/sat_arbiter_if.sv
// Requester-side bus of the saturating arbiter: level requests, operands,
// ack pulse and the shared result. Latency: n/a. Backpressure: req held to ack.
// Ports: req/inp from requesters; ack/outp/sat_flag/busy back from arbiter.
interface sat_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int IN_LEN  = 64,
  parameter int OUT_LEN = 32
);
  logic [NREQ-1:0]        req;
  logic [NREQ*IN_LEN-1:0] inp;
  logic [NREQ-1:0]        ack;
  logic [OUT_LEN-1:0]     outp;
  logic                   sat_flag;
  logic                   busy;

  // Requester side drives requests and operands.
  modport master (
    output req,
    output inp,
    input  ack,
    input  outp,
    input  sat_flag,
    input  busy
  );

  // Arbiter side consumes requests and returns results.
  modport slave (
    input  req,
    input  inp,
    output ack,
    output outp,
    output sat_flag,
    output busy
  );
endinterface

// File: rtl/intsat.sv
// Combinational truncate-and-saturate of a signed operand to OUT_LEN bits.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: din (IN_LEN signed) -> dout (IN_LEN-LTRUNC signed), sat = clamped.
module intsat #(
  parameter int IN_LEN = 64,
  parameter int LTRUNC = 32
) (
  input  logic [IN_LEN-1:0]        din,
  output logic [IN_LEN-LTRUNC-1:0] dout,
  output logic                     sat
);
  localparam int OUT_LEN = IN_LEN - LTRUNC;

  // The removed MSBs plus the new sign bit must all agree for the value
  // to be representable in OUT_LEN bits.
  logic [LTRUNC:0] top_bits;
  assign top_bits = din[IN_LEN-1:OUT_LEN-1];

  always_comb begin
    dout = din[OUT_LEN-1:0];
    sat  = 1'b0;
    if (!((&top_bits) || (~|top_bits))) begin
      sat = 1'b1;
      if (din[IN_LEN-1]) begin
        dout = {1'b1, {(OUT_LEN-1){1'b0}}};
      end else begin
        dout = {1'b0, {(OUT_LEN-1){1'b1}}};
      end
    end
  end
endmodule

// File: rtl/sat_rr_pick.sv
// Round-robin picker: first set request after the last granted index, wrapping.
// Latency: 0 cycles (combinational). Backpressure: none; caller decides when to use it.
// Ports: req, last -> gnt_oh (one-hot), gnt_idx (binary), any (some request set).
module sat_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);
  int                 cand;
  logic [IDX_W-1:0]   cand_idx;

  // Search last+1, last+2, ... last+NREQ (mod NREQ); last itself is
  // considered only after everyone else, which gives the rotation.
  always_comb begin
    gnt_oh   = '0;
    gnt_idx  = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(last) + k) % NREQ;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        gnt_idx         = cand_idx;
        gnt_oh[cand_idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sat_arbiter.sv
// Shares one registered truncate-and-saturate stage between NREQ requesters.
// Latency: req sampled -> ack pulse 2 cycles later; one grant every 3 cycles.
// Backpressure: requesters hold req high until ack; others wait their turn.
// Ports: clk, rst_L (async low); bus (req/inp in, ack/outp/sat_flag/busy out);
//        cnt_clr clears sat_cnt (NREQ packed CNT_W-bit saturation event counters).
module sat_arbiter
  import sat_arbiter_pkg::*;
#(
  parameter int IN_LEN = 64,
  parameter int LTRUNC = 32,
  parameter int NREQ   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_L,
  sat_arbiter_if.slave           bus,
  input  logic                   cnt_clr,
  output logic [NREQ*CNT_W-1:0]  sat_cnt
);
  localparam int OUT_LEN = out_len(IN_LEN, LTRUNC);
  localparam int IDX_W   = idx_width(NREQ);

  // Architectural state
  state_e                        state_q, state_d;
  logic [IN_LEN-1:0]             op_q, op_d;
  logic [IDX_W-1:0]              gidx_q, gidx_d;
  logic [NREQ-1:0]               gnt_q, gnt_d;
  logic [IDX_W-1:0]              last_q, last_d;
  logic [NREQ-1:0]               ack_q, ack_d;
  logic [OUT_LEN-1:0]            outp_q, outp_d;
  logic                          sat_q, sat_d;
  logic                          busy_q, busy_d;
  logic [NREQ-1:0][CNT_W-1:0]    cnt_q, cnt_d;

  // Picker and saturator results
  logic [NREQ-1:0]               pick_oh;
  logic [IDX_W-1:0]              pick_idx;
  logic                          pick_any;
  logic [OUT_LEN-1:0]            sat_dout;
  logic                          sat_hit;

  sat_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (bus.req),
    .last    (last_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Saturation works on the latched operand, so the requester's operand
  // only has to be stable in the cycle it is granted.
  intsat #(
    .IN_LEN (IN_LEN),
    .LTRUNC (LTRUNC)
  ) u_sat (
    .din  (op_q),
    .dout (sat_dout),
    .sat  (sat_hit)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    ack_d   = '0;       // ack is a single-cycle pulse
    outp_d  = outp_q;   // result holds until the next LATCH
    sat_d   = sat_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          op_d    = bus.inp[int'(pick_idx)*IN_LEN +: IN_LEN];
          gidx_d  = pick_idx;
          gnt_d   = pick_oh;
          last_d  = pick_idx;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        outp_d  = sat_dout;
        sat_d   = sat_hit;
        ack_d   = gnt_q;
        // Counters stick at all-ones rather than wrapping.
        if (sat_hit && (cnt_q[gidx_q] != {CNT_W{1'b1}})) begin
          cnt_d[gidx_q] = cnt_q[gidx_q] + CNT_W'(1);
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Host clear wins over a same-cycle increment; the FSM is unaffected.
    if (cnt_clr) begin
      cnt_d = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NREQ-1);  // requester 0 gets first priority
      ack_q   <= '0;
      outp_q  <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      outp_q  <= outp_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.outp     = outp_q;
  assign bus.sat_flag = sat_q;
  assign bus.busy     = busy_q;
  assign sat_cnt      = cnt_q;

endmodule

// File: tb/tb_sat_arbiter.sv
// Self-checking bench for sat_arbiter: scoreboard of expected results pushed
// when a request is driven and popped when the matching ack pulse appears.
// Counter width is narrowed so the sticky all-ones limit is reachable quickly.
module tb_sat_arbiter;
  localparam int NREQ    = 4;
  localparam int IN_LEN  = 64;
  localparam int LTRUNC  = 32;
  localparam int OUT_LEN = IN_LEN - LTRUNC;
  localparam int CNT_W   = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;

  typedef struct {
    int                 idx;
    logic [OUT_LEN-1:0] outp;
    logic               sat;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_L;
  logic                   cnt_clr;
  logic [NREQ*CNT_W-1:0]  sat_cnt;

  sat_arbiter_if #(.NREQ(NREQ), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN)) bus();

  sat_arbiter #(
    .IN_LEN (IN_LEN),
    .LTRUNC (LTRUNC),
    .NREQ   (NREQ),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_L   (rst_L),
    .bus     (bus),
    .cnt_clr (cnt_clr),
    .sat_cnt (sat_cnt)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   exp_cnt[NREQ];
  int   n_chk;
  int   n_fail;

  // Reference saturation using signed range comparison.
  function automatic exp_t model(input int idx, input logic [IN_LEN-1:0] v);
    exp_t   e;
    longint s;
    s     = longint'(v);
    e.idx = idx;
    if (s > 64'sd2147483647) begin
      e.outp = 32'h7FFF_FFFF;
      e.sat  = 1'b1;
    end else if (s < -64'sd2147483648) begin
      e.outp = 32'h8000_0000;
      e.sat  = 1'b1;
    end else begin
      e.outp = v[OUT_LEN-1:0];
      e.sat  = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input int idx, input logic [IN_LEN-1:0] v);
    bus.inp[idx*IN_LEN +: IN_LEN] = v;
    bus.req[idx] = 1'b1;
    sb.push_back(model(idx, v));
  endtask

  // Waits (bounded) on negedges for an ack pulse; cyc = negedges waited.
  task automatic wait_ack(output int cyc);
    cyc = 0;
    while (bus.ack == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Pops the next expectation and advances the counter model.
  task automatic take(output exp_t e, output logic [NREQ-1:0] ea);
    ea = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      ea[e.idx] = 1'b1;
      if (e.sat && exp_cnt[e.idx] < CMAX) exp_cnt[e.idx]++;
    end else begin
      e.idx = -1; e.outp = '0; e.sat = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_L = 1'b0; cnt_clr = 1'b0; bus.req = '0; bus.inp = '0;
    for (int i = 0; i < NREQ; i++) exp_cnt[i] = 0;
    repeat (2) @(negedge clk);
    n_chk++; if (bus.ack !== '0) begin n_fail++; $display("FAIL reset_ack got %b want 0", bus.ack); end
    n_chk++; if (bus.outp !== '0) begin n_fail++; $display("FAIL reset_outp got %h want 0", bus.outp); end
    n_chk++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b want 0", bus.sat_flag); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_chk++; if (sat_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", sat_cnt); end
    rst_L = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0 || bus.ack !== '0) begin n_fail++; $display("FAIL idle_quiet busy %b ack %b want 0", bus.busy, bus.ack); end
  endtask

  // One request at a time: values around the saturation boundaries.
  task automatic test_saturate();
    logic [IN_LEN-1:0] vals[7];
    int                idxs[7];
    int                cyc;
    exp_t              e;
    logic [NREQ-1:0]   ea;
    idxs = '{0, 1, 1, 2, 3, 0, 2};
    vals = '{64'h0000_0000_7FFF_FFFF, 64'h0000_0001_0000_0000, 64'h8000_0000_0000_0000,
             64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_7FFF_FFFF, 64'h0000_0000_8000_0000,
             64'hFFFF_FFFF_FFFF_FFFF};
    for (int t = 0; t < 7; t++) begin
      issue(idxs[t], vals[t]);
      wait_ack(cyc);
      take(e, ea);
      n_chk++; if (cyc != 2) begin n_fail++; $display("FAIL sat_latency[%0d] got %0d want 2", t, cyc); end
      n_chk++; if (bus.ack !== ea) begin n_fail++; $display("FAIL sat_ack[%0d] got %b want %b", t, bus.ack, ea); end
      n_chk++; if (bus.outp !== e.outp) begin n_fail++; $display("FAIL sat_outp[%0d] got %h want %h", t, bus.outp, e.outp); end
      n_chk++; if (bus.sat_flag !== e.sat) begin n_fail++; $display("FAIL sat_flag[%0d] got %b want %b", t, bus.sat_flag, e.sat); end
      n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL sat_busy[%0d] got %b want 1", t, bus.busy); end
      for (int i = 0; i < NREQ; i++) begin
        n_chk++;
        if (sat_cnt[i*CNT_W +: CNT_W] !== CNT_W'(exp_cnt[i])) begin
          n_fail++; $display("FAIL sat_cnt[%0d][%0d] got %0d want %0d", t, i, sat_cnt[i*CNT_W +: CNT_W], exp_cnt[i]);
        end
      end
      @(negedge clk);
      n_chk++; if (bus.ack !== '0) begin n_fail++; $display("FAIL ack_pulse[%0d] got %b want 0", t, bus.ack); end
      n_chk++; if (bus.outp !== e.outp) begin n_fail++; $display("FAIL outp_hold[%0d] got %h want %h", t, bus.outp, e.outp); end
      bus.req[idxs[t]] = 1'b0;
    end
  endtask

  // All requests held from reset: grants rotate 0,1,2,3,0 every 3 cycles.
  task automatic test_back_to_back();
    logic [IN_LEN-1:0] ops[NREQ];
    int                cyc;
    exp_t              e;
    logic [NREQ-1:0]   ea;
    ops = '{64'h0000_0000_0000_1234, 64'h0000_0002_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFB, 64'h8000_0000_0000_0000};
    rst_L = 1'b0;
    sb.delete();
    for (int i = 0; i < NREQ; i++) begin exp_cnt[i] = 0; issue(i, ops[i]); end
    sb.push_back(model(0, ops[0]));
    @(negedge clk);
    rst_L = 1'b1;
    for (int t = 0; t < NREQ + 1; t++) begin
      wait_ack(cyc);
      take(e, ea);
      n_chk++; if (cyc != 2) begin n_fail++; $display("FAIL rr_spacing[%0d] got %0d want 2", t, cyc); end
      n_chk++; if (bus.ack !== ea) begin n_fail++; $display("FAIL rr_order[%0d] got %b want %b", t, bus.ack, ea); end
      n_chk++; if (bus.outp !== e.outp || bus.sat_flag !== e.sat) begin
        n_fail++; $display("FAIL rr_result[%0d] got %h/%b want %h/%b", t, bus.outp, bus.sat_flag, e.outp, e.sat);
      end
      @(negedge clk);
    end
    bus.req = '0;
    n_chk++;
    if (sat_cnt !== {CNT_W'(exp_cnt[3]), CNT_W'(exp_cnt[2]), CNT_W'(exp_cnt[1]), CNT_W'(exp_cnt[0])}) begin
      n_fail++; $display("FAIL rr_cnt got %h", sat_cnt);
    end
  endtask

  // Drive requester 3 to the counter limit, one more clamp, then clear vs clamp.
  task automatic test_cnt_limit();
    logic [IN_LEN-1:0] v;
    int                n;
    int                cyc;
    exp_t              e;
    logic [NREQ-1:0]   ea;
    v = 64'h0000_0100_0000_0000;
    n = CMAX - exp_cnt[3];
    bus.inp[3*IN_LEN +: IN_LEN] = v;
    bus.req[3] = 1'b1;
    for (int t = 0; t <= n; t++) begin
      sb.push_back(model(3, v));
      wait_ack(cyc);
      take(e, ea);
      n_chk++; if (bus.ack !== ea || bus.sat_flag !== 1'b1) begin
        n_fail++; $display("FAIL lim_ack[%0d] got %b/%b want %b/1", t, bus.ack, bus.sat_flag, ea);
      end
      if (t >= n - 1) begin
        n_chk++;
        if (sat_cnt[3*CNT_W +: CNT_W] !== CNT_W'(CMAX)) begin
          n_fail++; $display("FAIL cnt_sticky[%0d] got %0d want %0d", t, sat_cnt[3*CNT_W +: CNT_W], CMAX);
        end
      end
      @(negedge clk);
    end
    // req[3] still high: this grant's clamp coincides with cnt_clr.
    sb.push_back(model(3, v));
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy got %b want 1", bus.busy); end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    take(e, ea);
    for (int i = 0; i < NREQ; i++) exp_cnt[i] = 0;
    n_chk++; if (bus.ack !== ea) begin n_fail++; $display("FAIL clr_ack got %b want %b", bus.ack, ea); end
    n_chk++; if (sat_cnt !== '0) begin n_fail++; $display("FAIL clr_cnt got %h want 0", sat_cnt); end
    @(negedge clk);
    bus.req[3] = 1'b0;
  endtask

  // Reset while a grant is in LATCH: no ack, outputs zero, pointer restarts.
  task automatic test_reset_mid();
    logic [IN_LEN-1:0] v0, v1;
    int                cyc;
    int                stray;
    exp_t              e;
    logic [NREQ-1:0]   ea;
    v0 = 64'h0000_0000_0000_0042;
    v1 = 64'hF000_0000_0000_0000;
    bus.inp[1*IN_LEN +: IN_LEN] = v1;
    bus.req[1] = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b want 1", bus.busy); end
    rst_L = 1'b0;
    #1;
    for (int i = 0; i < NREQ; i++) exp_cnt[i] = 0;
    n_chk++; if (bus.ack !== '0) begin n_fail++; $display("FAIL mid_ack got %b want 0", bus.ack); end
    n_chk++; if (bus.outp !== '0 || bus.sat_flag !== 1'b0) begin
      n_fail++; $display("FAIL mid_outp got %h/%b want 0/0", bus.outp, bus.sat_flag);
    end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy0 got %b want 0", bus.busy); end
    stray = 0;
    repeat (3) begin @(negedge clk); if (bus.ack != '0) stray++; end
    n_chk++; if (stray != 0) begin n_fail++; $display("FAIL mid_stray_ack got %0d want 0", stray); end
    issue(0, v0);
    sb.push_back(model(1, v1));
    rst_L = 1'b1;
    for (int t = 0; t < 2; t++) begin
      wait_ack(cyc);
      take(e, ea);
      n_chk++; if (cyc != 2 || bus.ack !== ea) begin
        n_fail++; $display("FAIL mid_order[%0d] got %b after %0d want %b after 2", t, bus.ack, cyc, ea);
      end
      n_chk++; if (bus.outp !== e.outp || bus.sat_flag !== e.sat) begin
        n_fail++; $display("FAIL mid_result[%0d] got %h/%b want %h/%b", t, bus.outp, bus.sat_flag, e.outp, e.sat);
      end
      @(negedge clk);
      if (e.idx >= 0) bus.req[e.idx] = 1'b0;
    end
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_left got %0d want 0", sb.size()); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_saturate();
    test_back_to_back();
    test_cnt_limit();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
